demux1to2_stream_etiquetas: RTL and testbench
=============================================

Name: demux1to2_stream_etiquetas

Overview:
- Return-direction counterpart of the team's 2:1 select mux.
- Takes one valid/ready word stream and steers each word, per its SEL bit, to one of two output streams, O0 or O1.
- Each output is buffered by its own small FIFO, so one stalled consumer never corrupts the other.
- Sits between the tag-logic producer and two downstream consumers, for example two tag-compare lanes.

Parameters:
- k, 1: data width in bits; must be ≥1.
- DEPTH, 2: entries per output FIFO; power of two, ≥2.
- CW, $clog2(DEPTH)+1: occupancy counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous and active-high; clears all state.
- A  input  k  input data word.
- SEL  input  1  destination select: 0 sends the word to O0, 1 sends it to O1.
- in_valid  input  1  A/SEL are valid this cycle.
- in_ready  output  1  block accepts A this cycle.
- O0  output  k  head word of FIFO 0.
- o0_valid  output  1  FIFO 0 is non-empty.
- o0_ready  input  1  consumer 0 takes O0.
- O1  output  k  head word of FIFO 1.
- o1_valid  output  1  FIFO 1 is non-empty.
- o1_ready  input  1  consumer 1 takes O1.
- cnt0  output  CW  FIFO 0 occupancy.
- cnt1  output  CW  FIFO 1 occupancy.

Behaviour:
- Reset (asynchronous, rst=1):
  - Pointers and counts go to 0.
  - o0_valid=o1_valid=0, cnt0=cnt1=0.
  - O0/O1 read 0, because storage is cleared.
  - in_ready follows its equation, so it reads 1 once rst deasserts.
  - A reset mid-operation discards all buffered words; no partial transfer survives.
- Accept rule:
  - in_ready = SEL ? !full1 : !full0. It is combinational on SEL and registered full flags only, never on o*_ready.
  - A word is accepted when in_valid & in_ready.
  - A word for a full FIFO stalls the input, even if the other FIFO has room. Order is preserved, with no reordering across SEL.
- Output rule:
  - Pop on oN_valid & oN_ready.
  - oN_valid = (cntN != 0); ON = mem_N[rd_ptr_N].
- Latency: an accepted word is visible on its output the next cycle. There is no same-cycle bypass.
- Occupancy per FIFO:
  - push only: cnt+1.
  - pop only: cnt-1.
  - push and pop in the same cycle: cnt unchanged, both pointers advance.
  - Push while full cannot happen, because in_ready blocks it.
  - Pop while empty is ignored, since oN_valid=0.
- Pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH.
- full = (cnt == DEPTH); empty = (cnt == 0).
- FIFOs are independent: a pop on O0 and a push into O1 in the same cycle are both honoured.
- SEL or A changing while in_valid=1 and in_ready=0 is legal. The block samples only on acceptance.
- ON holds its value while oN_valid=1 and oN_ready=0 (stable until popped).
- X on SEL while in_valid=0 must not change state.

Decomposition:
- Package demux_etq_pkg:
  - localparam SEL_O0=1'b0, SEL_O1=1'b1.
  - Function clog2-based CW helper.
  - No typedefs needed beyond logic [k-1:0].
- One sub-module, stream_fifo_etq (k, DEPTH):
  - clk/rst, push/push_data, pop, head, valid, full, count.
  - Instantiated twice.
- The top level is only the SEL steering of push and the in_ready mux.

Test Plan:
1. Reset then idle: rst=1 for 3 cycles, release → in_ready=1, o0_valid=o1_valid=0, cnt0=cnt1=0.
2. Steering, k=8:
   - Stimulus: accept A=8'hA5 SEL=0, then A=8'h3C SEL=1, with both o*_ready=1.
   - Response: O0=A5 with o0_valid one cycle after the first accept; O1=3C one cycle after the second; cnts return to 0.
3. Backpressure, DEPTH=2:
   - Stimulus: o0_ready=0; push 8'h01, 8'h02, 8'h03, all SEL=0.
   - Response: cnt0=2 after two accepts; in_ready=0 while SEL=0. Then set o0_ready=1 → O0 pops 01 then 02, and 03 is accepted. No loss, order preserved.
4. Cross-lane independence:
   - Stimulus: FIFO 0 full (o0_ready=0); present SEL=1, A=8'h77.
   - Response: in_ready=1, the word is accepted, O1=77 next cycle, FIFO 0 contents unchanged.
5. Simultaneous push/pop:
   - Stimulus: cnt0=1 holding 8'h10; same cycle pop O0 and push 8'h11 with SEL=0.
   - Response: cnt0 stays 1, next O0=11. Repeat for 2·DEPTH+1 cycles to exercise pointer wrap; data must match a scoreboard.
6. Reset mid-operation:
   - Stimulus: cnt0=2, cnt1=1; assert rst asynchronously between clock edges.
   - Response: o0_valid=o1_valid=0 and cnt0=cnt1=0 immediately, without waiting for clk; no stale word appears after release.

Source files
------------

// File: rtl/demux1to2_stream_etiquetas_pkg.sv
// Shared constants for the 1:2 tag-stream demux: select encodings and
// the occupancy-counter width helper (a counter must be able to hold DEPTH itself).
package demux_etq_pkg;

    localparam logic SEL_O0 = 1'b0;
    localparam logic SEL_O1 = 1'b1;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/demux1to2_stream_etiquetas_fifo.sv
// Small circular FIFO with a registered occupancy count; head is visible the
// cycle after a push (no bypass), and storage is cleared on reset so head reads 0.
module stream_fifo_etq
    import demux_etq_pkg::*;
#(
    parameter  int k     = 1,
    parameter  int DEPTH = 2,
    localparam int CW    = cnt_width(DEPTH),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [k-1:0]  push_data_i,
    input  logic          pop_i,
    output logic [k-1:0]  head_o,
    output logic          valid_o,
    output logic          full_o,
    output logic [CW-1:0] count_o
);

    logic [k-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push_en;
    logic          pop_en;

    assign valid_o = (cnt_q != '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Guard both sides locally so an over-eager caller cannot corrupt the count.
    assign push_en = push_i & ~full_o;
    assign pop_en  = pop_i & valid_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_en, pop_en})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_en) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/demux1to2_stream_etiquetas.sv
// 1:2 stream demux: steers each accepted word by SEL into one of two FIFOs.
// in_ready depends only on SEL and the target FIFO's registered full flag, so order is kept across lanes.
module demux1to2_stream_etiquetas
    import demux_etq_pkg::*;
#(
    parameter  int k     = 1,
    parameter  int DEPTH = 2,
    localparam int CW    = cnt_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [k-1:0]  A,
    input  logic          SEL,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [k-1:0]  O0,
    output logic          o0_valid,
    input  logic          o0_ready,
    output logic [k-1:0]  O1,
    output logic          o1_valid,
    input  logic          o1_ready,
    output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1
);

    logic full0;
    logic full1;
    logic accept;
    logic push0;
    logic push1;

    // A word bound for a full lane stalls the whole input, even if the other lane has room.
    assign in_ready = (SEL == SEL_O1) ? ~full1 : ~full0;
    assign accept   = in_valid & in_ready;
    assign push0    = accept & (SEL == SEL_O0);
    assign push1    = accept & (SEL == SEL_O1);

    stream_fifo_etq #(
        .k     (k),
        .DEPTH (DEPTH)
    ) u_fifo0 (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push0),
        .push_data_i (A),
        .pop_i       (o0_ready),
        .head_o      (O0),
        .valid_o     (o0_valid),
        .full_o      (full0),
        .count_o     (cnt0)
    );

    stream_fifo_etq #(
        .k     (k),
        .DEPTH (DEPTH)
    ) u_fifo1 (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push1),
        .push_data_i (A),
        .pop_i       (o1_ready),
        .head_o      (O1),
        .valid_o     (o1_valid),
        .full_o      (full1),
        .count_o     (cnt1)
    );

endmodule

// File: tb/tb_demux1to2_stream_etiquetas.sv
// Scoreboard bench for the 1:2 stream demux: the driver predicts acceptance from
// per-lane reference queues and pushes expected words; a monitor compares and pops.
module tb_demux1to2_stream_etiquetas;

    localparam int K     = 8;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [K-1:0]  A = '0;
    logic          SEL = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [K-1:0]  O0, O1;
    logic          o0_valid, o1_valid;
    logic          o0_ready = 1'b0;
    logic          o1_ready = 1'b0;
    logic [CW-1:0] cnt0, cnt1;

    int tests = 0;
    int fails = 0;

    // Reference model: each queue is exactly the ordered contents of one lane.
    logic [K-1:0] q0[$];
    logic [K-1:0] q1[$];

    demux1to2_stream_etiquetas #(
        .k     (K),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .A        (A),
        .SEL      (SEL),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .O0       (O0),
        .o0_valid (o0_valid),
        .o0_ready (o0_ready),
        .O1       (O1),
        .o1_valid (o1_valid),
        .o1_ready (o1_ready),
        .cnt0     (cnt0),
        .cnt1     (cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One cycle of stimulus: inputs at negedge, ready check at +1, model push at +3.
    task automatic drive(input logic v, input logic s, input logic [K-1:0] a,
                         input logic r0, input logic r1, output logic acc);
        logic exp_rdy;
        @(negedge clk);
        in_valid = v;
        SEL      = s;
        A        = a;
        o0_ready = r0;
        o1_ready = r1;
        #1;
        exp_rdy = s ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        acc = v && exp_rdy;
        #2;
        if (acc) begin
            if (s) q1.push_back(a);
            else   q0.push_back(a);
        end
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'($urandom), 8'($urandom), 1'b1, 1'b1, acc);
        end
    endtask

    // Monitor: compare every lane each cycle, pop the model when a transfer will occur.
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            chk("o0_valid", {31'd0, o0_valid}, {31'd0, q0.size() != 0});
            chk("cnt0", 32'(cnt0), 32'(q0.size()));
            if (q0.size() != 0) begin
                chk("O0", 32'(O0), 32'(q0[0]));
                if (o0_ready) void'(q0.pop_front());
            end
            chk("o1_valid", {31'd0, o1_valid}, {31'd0, q1.size() != 0});
            chk("cnt1", 32'(cnt1), 32'(q1.size()));
            if (q1.size() != 0) begin
                chk("O1", 32'(O1), 32'(q1[0]));
                if (o1_ready) void'(q1.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic acc;
        bit   done;

        // Reset then idle
        repeat (3) @(posedge clk);
        #1;
        chk("rst_o0_valid", {31'd0, o0_valid}, 32'd0);
        chk("rst_o1_valid", {31'd0, o1_valid}, 32'd0);
        chk("rst_cnt0", 32'(cnt0), 32'd0);
        chk("rst_cnt1", 32'(cnt1), 32'd0);
        chk("rst_O0", 32'(O0), 32'd0);
        chk("rst_O1", 32'(O1), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Steering
        drive(1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, acc);
        drive(1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, acc);
        idle(3);

        // Backpressure on lane 0
        drive(1'b1, 1'b0, 8'h01, 1'b0, 1'b1, acc);
        drive(1'b1, 1'b0, 8'h02, 1'b0, 1'b1, acc);
        drive(1'b1, 1'b0, 8'h03, 1'b0, 1'b1, acc);
        chk("bp_cnt0_full", 32'(cnt0), 32'd2);
        drive(1'b1, 1'b0, 8'h03, 1'b0, 1'b1, acc);
        done = 1'b0;
        for (int i = 0; i < 8 && !done; i++) begin
            drive(1'b1, 1'b0, 8'h03, 1'b1, 1'b1, acc);
            done = acc;
        end
        chk("bp_eventual_accept", {31'd0, done}, 32'd1);
        idle(4);

        // Cross-lane independence: lane 0 full, lane 1 still accepts
        drive(1'b1, 1'b0, 8'h21, 1'b0, 1'b0, acc);
        drive(1'b1, 1'b0, 8'h22, 1'b0, 1'b0, acc);
        drive(1'b1, 1'b1, 8'h77, 1'b0, 1'b0, acc);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, acc);
        chk("xl_O1", 32'(O1), 32'h77);
        chk("xl_O0_head", 32'(O0), 32'h21);
        idle(4);

        // Simultaneous push/pop across pointer wrap
        drive(1'b1, 1'b0, 8'h10, 1'b0, 1'b1, acc);
        for (int i = 0; i < 2 * DEPTH + 1; i++) begin
            drive(1'b1, 1'b0, 8'(8'h11 + i), 1'b1, 1'b1, acc);
        end
        idle(3);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0), acc);
        end
        idle(4);

        // Reset mid-operation, asserted between clock edges
        drive(1'b1, 1'b0, 8'h5A, 1'b0, 1'b0, acc);
        drive(1'b1, 1'b0, 8'h5B, 1'b0, 1'b0, acc);
        drive(1'b1, 1'b1, 8'h6C, 1'b0, 1'b0, acc);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, acc);
        @(posedge clk);
        #2;
        rst = 1'b1;
        q0.delete();
        q1.delete();
        #1;
        chk("mid_rst_o0_valid", {31'd0, o0_valid}, 32'd0);
        chk("mid_rst_o1_valid", {31'd0, o1_valid}, 32'd0);
        chk("mid_rst_cnt0", 32'(cnt0), 32'd0);
        chk("mid_rst_cnt1", 32'(cnt1), 32'd0);
        chk("mid_rst_O0", 32'(O0), 32'd0);
        chk("mid_rst_O1", 32'(O1), 32'd0);
        idle(2);
        #1;
        rst = 1'b0;
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
